// File: rtl/apb_rr_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : apb_rr_fabric
//  Purpose  : APB interconnect with MST masters, round-robin arbitration and
//             SLV slaves decoded from the upper address bits.
//             Optional ACCESS timeout: define APB_RR_FABRIC_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module apb_rr_fabric #(
    parameter int MST      = 2,
    parameter int SLV      = 4,
    parameter int MST_ADDR = 32,
    parameter int SLV_ADDR = 12,
    parameter int DATA     = 32,
    parameter int TIMEOUT  = 256
) (
    input  logic                     pclk,
    input  logic                     preset_n,
    input  logic [MST-1:0]           mst_psel,
    input  logic [MST-1:0]           mst_penable,
    input  logic [MST-1:0]           mst_pwrite,
    input  logic [MST*3-1:0]         mst_pprot,
    input  logic [MST*MST_ADDR-1:0]  mst_paddr,
    input  logic [MST*4-1:0]         mst_pstrb,
    input  logic [MST*DATA-1:0]      mst_pwdata,
    output logic [MST*DATA-1:0]      mst_prdata,
    output logic [MST-1:0]           mst_pslverr,
    output logic [MST-1:0]           mst_pready,
    output logic [SLV-1:0]           slv_psel,
    output logic [SLV-1:0]           slv_penable,
    output logic [SLV-1:0]           slv_pwrite,
    output logic [SLV*3-1:0]         slv_pprot,
    output logic [SLV*SLV_ADDR-1:0]  slv_paddr,
    output logic [SLV*4-1:0]         slv_pstrb,
    output logic [SLV*DATA-1:0]      slv_pwdata,
    input  logic [SLV*DATA-1:0]      slv_prdata,
    input  logic [SLV-1:0]           slv_pslverr,
    input  logic [SLV-1:0]           slv_pready
);

    localparam int PW  = (MST > 1) ? $clog2(MST) : 1;
    localparam int PW1 = PW + 1;
    localparam int IW  = MST_ADDR - SLV_ADDR;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         grant_q, grant_d;
    logic [2:0]            prot_q, prot_d;
    logic [MST_ADDR-1:0]   addr_q, addr_d;
    logic                  write_q, write_d;
    logic [3:0]            strb_q, strb_d;
    logic [DATA-1:0]       wdata_q, wdata_d;

    logic [MST-1:0]        psel_rot;
    logic                  arb_hit;
    logic [PW-1:0]         arb_win;
    logic [PW1-1:0]        arb_sum;
    logic [2:0]            win_prot;
    logic [MST_ADDR-1:0]   win_addr;
    logic                  win_write;
    logic [3:0]            win_strb;
    logic [DATA-1:0]       win_wdata;

    logic [IW-1:0]         slv_idx;
    logic                  dec_err;
    logic [SLV-1:0]        slv_oh;
    logic                  sel_rdy;
    logic                  sel_err;
    logic [DATA-1:0]       sel_rdata;
    logic [PW-1:0]         ptr_nxt;

    logic                  resp_valid;
    logic                  resp_err;
    logic [DATA-1:0]       resp_data;
    logic                  unused_ok;

    // Rotate requests so bit 0 is the current priority holder
    assign psel_rot = MST'({mst_psel, mst_psel} >> ptr_q);

    always_comb begin
        arb_hit = 1'b0;
        arb_win = '0;
        arb_sum = '0;
        for (int i = 0; i < MST; i++) begin
            if (!arb_hit && psel_rot[i]) begin
                arb_hit = 1'b1;
                arb_sum = {1'b0, ptr_q} + PW1'(i);
                arb_win = (arb_sum >= PW1'(MST)) ? PW'(arb_sum - PW1'(MST)) : PW'(arb_sum);
            end
        end
    end

    always_comb begin
        win_prot  = '0;
        win_addr  = '0;
        win_write = 1'b0;
        win_strb  = '0;
        win_wdata = '0;
        for (int m = 0; m < MST; m++) begin
            if (arb_win == PW'(m)) begin
                win_prot  = mst_pprot[m*3 +: 3];
                win_addr  = mst_paddr[m*MST_ADDR +: MST_ADDR];
                win_write = mst_pwrite[m];
                win_strb  = mst_pstrb[m*4 +: 4];
                win_wdata = mst_pwdata[m*DATA +: DATA];
            end
        end
    end

    assign slv_idx = addr_q[MST_ADDR-1:SLV_ADDR];
    assign dec_err = (slv_idx >= IW'(SLV));
    assign ptr_nxt = (grant_q == PW'(MST-1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        slv_oh    = '0;
        sel_rdy   = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int s = 0; s < SLV; s++) begin
            if (!dec_err && (slv_idx == IW'(s))) begin
                slv_oh[s] = 1'b1;
                sel_rdy   = slv_pready[s];
                sel_err   = slv_pslverr[s];
                sel_rdata = slv_prdata[s*DATA +: DATA];
            end
        end
    end

`ifdef APB_RR_FABRIC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign unused_ok = ^mst_penable;
`else
    assign unused_ok = ^{mst_penable, 32'(TIMEOUT)};
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        prot_d     = prot_q;
        addr_d     = addr_q;
        write_d    = write_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_data  = '0;
`ifdef APB_RR_FABRIC_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    grant_d = arb_win;
                    prot_d  = win_prot;
                    addr_d  = win_addr;
                    write_d = win_write;
                    strb_d  = win_strb;
                    wdata_d = win_wdata;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = dec_err ? ERR : ACCESS;
`ifdef APB_RR_FABRIC_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (sel_rdy) begin
                    resp_valid = 1'b1;
                    resp_err   = sel_err;
                    resp_data  = sel_rdata;
                    ptr_d      = ptr_nxt;
                    state_d    = IDLE;
                end
`ifdef APB_RR_FABRIC_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_valid = 1'b1;
                    resp_err   = 1'b1;
                    ptr_d      = ptr_nxt;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                ptr_d      = ptr_nxt;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            prot_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            prot_q  <= prot_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
        end
    end

    // A master that has dropped psel no longer owns the transfer; its response is discarded
    always_comb begin
        mst_pready  = '0;
        mst_pslverr = '0;
        mst_prdata  = '0;
        for (int m = 0; m < MST; m++) begin
            if (resp_valid && (grant_q == PW'(m)) && mst_psel[m]) begin
                mst_pready[m]              = 1'b1;
                mst_pslverr[m]             = resp_err;
                mst_prdata[m*DATA +: DATA] = resp_data;
            end
        end
    end

    assign slv_psel    = slv_oh & {SLV{(state_q == SETUP) || (state_q == ACCESS)}};
    assign slv_penable = slv_oh & {SLV{state_q == ACCESS}};
    assign slv_pwrite  = {SLV{write_q}};

    for (genvar s = 0; s < SLV; s++) begin : g_bcast
        assign slv_pprot[s*3 +: 3]                = prot_q;
        assign slv_paddr[s*SLV_ADDR +: SLV_ADDR]  = addr_q[SLV_ADDR-1:0];
        assign slv_pstrb[s*4 +: 4]                = strb_q;
        assign slv_pwdata[s*DATA +: DATA]         = wdata_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_rr_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_rr_fabric
//  Purpose  : Directed bench for apb_rr_fabric with a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_rr_fabric;

    localparam int MST = 2;
    localparam int SLV = 4;

    logic                pclk;
    logic                preset_n;
    logic [MST-1:0]      mst_psel, mst_penable, mst_pwrite;
    logic [MST*3-1:0]    mst_pprot;
    logic [MST*32-1:0]   mst_paddr;
    logic [MST*4-1:0]    mst_pstrb;
    logic [MST*32-1:0]   mst_pwdata;
    logic [MST*32-1:0]   mst_prdata;
    logic [MST-1:0]      mst_pslverr, mst_pready;
    logic [SLV-1:0]      slv_psel, slv_penable, slv_pwrite;
    logic [SLV*3-1:0]    slv_pprot;
    logic [SLV*12-1:0]   slv_paddr;
    logic [SLV*4-1:0]    slv_pstrb;
    logic [SLV*32-1:0]   slv_pwdata;
    logic [SLV*32-1:0]   slv_prdata;
    logic [SLV-1:0]      slv_pslverr, slv_pready;

    apb_rr_fabric #(
        .MST(MST), .SLV(SLV), .MST_ADDR(32), .SLV_ADDR(12), .DATA(32), .TIMEOUT(8)
    ) dut (
        .pclk(pclk), .preset_n(preset_n),
        .mst_psel(mst_psel), .mst_penable(mst_penable), .mst_pwrite(mst_pwrite),
        .mst_pprot(mst_pprot), .mst_paddr(mst_paddr), .mst_pstrb(mst_pstrb),
        .mst_pwdata(mst_pwdata), .mst_prdata(mst_prdata), .mst_pslverr(mst_pslverr),
        .mst_pready(mst_pready), .slv_psel(slv_psel), .slv_penable(slv_penable),
        .slv_pwrite(slv_pwrite), .slv_pprot(slv_pprot), .slv_paddr(slv_paddr),
        .slv_pstrb(slv_pstrb), .slv_pwdata(slv_pwdata), .slv_prdata(slv_prdata),
        .slv_pslverr(slv_pslverr), .slv_pready(slv_pready)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [7:0]  mst;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    int          wait_cfg  [SLV];
    logic [31:0] rdata_cfg [SLV];
    logic        err_cfg   [SLV];
    int          acc_cnt   [SLV];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave model: pready rises after wait_cfg[s] ACCESS cycles
    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int s = 0; s < SLV; s++) acc_cnt[s] <= 0;
        end else begin
            for (int s = 0; s < SLV; s++) begin
                if (slv_psel[s] && slv_penable[s] && !slv_pready[s]) acc_cnt[s] <= acc_cnt[s] + 1;
                else acc_cnt[s] <= 0;
            end
        end
    end

    always_comb begin
        slv_pready  = '0;
        slv_pslverr = '0;
        slv_prdata  = '0;
        for (int s = 0; s < SLV; s++) begin
            slv_pready[s]           = (acc_cnt[s] >= wait_cfg[s]);
            slv_pslverr[s]          = err_cfg[s];
            slv_prdata[s*32 +: 32]  = rdata_cfg[s];
        end
    end

    // Response monitor: every completion must match the head of the scoreboard
    always @(negedge pclk) begin
        exp_t e;
        for (int m = 0; m < MST; m++) begin
            if (mst_pready[m] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("sb_spurious_resp", 64'(m), 64'hFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_master", 64'(m), 64'(e.mst));
                    check("sb_prdata", 64'(mst_prdata[m*32 +: 32]), 64'(e.data));
                    check("sb_pslverr", 64'(mst_pslverr[m]), 64'(e.err));
                end
            end else if (preset_n === 1'b1) begin
                check("idle_master_out", {31'd0, mst_pslverr[m], mst_prdata[m*32 +: 32]}, 64'd0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic set_req(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
        mst_psel[m]            = 1'b1;
        mst_penable[m]         = 1'b0;
        mst_pwrite[m]          = w;
        mst_paddr[m*32 +: 32]  = a;
        mst_pwdata[m*32 +: 32] = d;
        mst_pstrb[m*4 +: 4]    = 4'hF;
        mst_pprot[m*3 +: 3]    = 3'b010;
    endtask

    task automatic clr_req(input int m);
        mst_psel[m]    = 1'b0;
        mst_penable[m] = 1'b0;
    endtask

    task automatic push(input int m, input logic [31:0] d, input logic err);
        exp_t e;
        e.mst  = 8'(m);
        e.data = d;
        e.err  = err;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset_n    = 1'b0;
        mst_psel    = '0;
        mst_penable = '0;
        mst_pwrite  = '0;
        mst_pprot   = '0;
        mst_paddr   = '0;
        mst_pstrb   = '0;
        mst_pwdata  = '0;
        for (int s = 0; s < SLV; s++) begin
            wait_cfg[s] = 0;
            err_cfg[s]  = 1'b0;
        end
        rdata_cfg[0] = 32'h1111_0000;
        rdata_cfg[1] = 32'hCAFE_F00D;
        rdata_cfg[2] = 32'h2222_2222;
        rdata_cfg[3] = 32'h3333_0000;

        step(2);
        check("rst_slv_psel", 64'(slv_psel), 64'd0);
        check("rst_slv_penable", 64'(slv_penable), 64'd0);
        check("rst_mst_pready", 64'(mst_pready), 64'd0);
        check("rst_mst_pslverr", 64'(mst_pslverr), 64'd0);
        check("rst_slv_paddr", 64'(slv_paddr[11:0]), 64'd0);
        check("rst_slv_pwdata", 64'(slv_pwdata[31:0]), 64'd0);
        preset_n = 1'b1;
        step(1);

        // Zero-wait read through slave 1
        set_req(0, 32'h0000_1004, 1'b0, 32'h0);
        push(0, 32'hCAFE_F00D, 1'b0);
        step(1);
        check("rd_setup_psel", 64'(slv_psel), 64'b0010);
        check("rd_setup_penable", 64'(slv_penable), 64'd0);
        check("rd_setup_pready", 64'(mst_pready), 64'd0);
        check("rd_setup_paddr", 64'(slv_paddr[1*12 +: 12]), 64'h004);
        step(1);
        check("rd_access_penable", 64'(slv_penable), 64'b0010);
        check("rd_access_pready", 64'(mst_pready), 64'b01);
        check("rd_access_prdata", 64'(mst_prdata[31:0]), 64'hCAFE_F00D);
        step(1);
        clr_req(0);

        // Decode error: slave index 5
        set_req(1, 32'h0000_5000, 1'b1, 32'h1234_5678);
        push(1, 32'h0, 1'b1);
        step(1);
        check("derr_setup_psel", 64'(slv_psel), 64'd0);
        step(1);
        check("derr_psel", 64'(slv_psel), 64'd0);
        check("derr_pready", 64'(mst_pready), 64'b10);
        check("derr_pslverr", 64'(mst_pslverr), 64'b10);
        check("derr_prdata", 64'(mst_prdata[63:32]), 64'd0);
        step(1);
        clr_req(1);

        // Continuous requests from both masters alternate grants
        set_req(0, 32'h0000_0010, 1'b0, 32'h0);
        set_req(1, 32'h0000_3020, 1'b0, 32'h0);
        push(0, 32'h1111_0000, 1'b0);
        push(1, 32'h3333_0000, 1'b0);
        push(0, 32'h1111_0000, 1'b0);
        push(1, 32'h3333_0000, 1'b0);
        step(12);
        clr_req(0);
        clr_req(1);
        check("rr_all_done", 64'(sb.size()), 64'd0);

        // Wait-state slave returning an error; payload must stay stable
        wait_cfg[2] = 3;
        err_cfg[2]  = 1'b1;
        set_req(0, 32'h0000_2ABC, 1'b1, 32'hDEAD_BEEF);
        push(0, 32'h2222_2222, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("ws_paddr", 64'(slv_paddr[2*12 +: 12]), 64'hABC);
            check("ws_pwdata", 64'(slv_pwdata[2*32 +: 32]), 64'hDEAD_BEEF);
            check("ws_pwrite", 64'(slv_pwrite[2]), 64'd1);
            check("ws_psel", 64'(slv_psel), 64'b0100);
            check("ws_pready", 64'(mst_pready), (k == 5) ? 64'b01 : 64'b00);
        end
        check("ws_pslverr", 64'(mst_pslverr), 64'b01);
        step(1);
        clr_req(0);
        wait_cfg[2] = 0;
        err_cfg[2]  = 1'b0;

        // Master drops psel mid-transfer: slave transfer completes, response dropped
        wait_cfg[0] = 2;
        set_req(1, 32'h0000_0040, 1'b0, 32'h0);
        step(1);
        check("drop_setup_psel", 64'(slv_psel), 64'b0001);
        step(1);
        clr_req(1);
        check("drop_access1", 64'(slv_penable), 64'b0001);
        step(1);
        check("drop_access2", 64'(slv_penable), 64'b0001);
        step(1);
        check("drop_access3", 64'(slv_penable), 64'b0001);
        check("drop_no_pready", 64'(mst_pready), 64'd0);
        step(1);
        check("drop_idle_psel", 64'(slv_psel), 64'd0);
        wait_cfg[0] = 0;

        // Second master waits for the ongoing transfer
        wait_cfg[1] = 2;
        set_req(0, 32'h0000_1008, 1'b0, 32'h0);
        push(0, 32'hCAFE_F00D, 1'b0);
        push(1, 32'h3333_0000, 1'b0);
        step(1);
        set_req(1, 32'h0000_300C, 1'b0, 32'h0);
        check("hold_setup_psel", 64'(slv_psel), 64'b0010);
        step(1);
        check("hold_access_psel", 64'(slv_psel), 64'b0010);
        step(3);
        clr_req(0);
        step(1);
        check("hold_next_psel", 64'(slv_psel), 64'b1000);
        step(2);
        clr_req(1);
        wait_cfg[1] = 0;

`ifdef APB_RR_FABRIC_TIMEOUT_EN
        // Slave never ready: timeout after 8 ACCESS cycles
        wait_cfg[1] = 1000;
        set_req(0, 32'h0000_1000, 1'b0, 32'h0);
        push(0, 32'h0, 1'b1);
        step(8);
        check("to_pre_pready", 64'(mst_pready), 64'd0);
        step(1);
        check("to_pready", 64'(mst_pready), 64'b01);
        check("to_pslverr", 64'(mst_pslverr), 64'b01);
        check("to_prdata", 64'(mst_prdata[31:0]), 64'd0);
        step(1);
        check("to_psel_clear", 64'(slv_psel), 64'd0);
        clr_req(0);
        wait_cfg[1] = 0;
`endif

        // Completion by master0 moves the pointer to master1
        set_req(0, 32'h0000_1004, 1'b0, 32'h0);
        push(0, 32'hCAFE_F00D, 1'b0);
        step(3);
        clr_req(0);

        // Reset during ACCESS: transfer abandoned, pointer back to master0
        wait_cfg[0] = 10;
        set_req(0, 32'h0000_0000, 1'b0, 32'h0);
        step(2);
        check("rst_mid_access", 64'(slv_penable), 64'b0001);
        step(1);
        preset_n = 1'b0;
        #1;
        check("rstm_slv_psel", 64'(slv_psel), 64'd0);
        check("rstm_slv_penable", 64'(slv_penable), 64'd0);
        check("rstm_mst_pready", 64'(mst_pready), 64'd0);
        check("rstm_mst_pslverr", 64'(mst_pslverr), 64'd0);
        check("rstm_slv_pwdata", 64'(slv_pwdata[31:0]), 64'd0);
        wait_cfg[0] = 0;
        set_req(0, 32'h0000_0080, 1'b0, 32'h0);
        set_req(1, 32'h0000_3084, 1'b0, 32'h0);
        step(2);
        preset_n = 1'b1;
        push(0, 32'h1111_0000, 1'b0);
        push(1, 32'h3333_0000, 1'b0);
        step(1);
        check("post_rst_grant", 64'(slv_psel), 64'b0001);
        step(5);
        clr_req(0);
        clr_req(1);

        step(3);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_rr_fabric.md
APB_RR_FABRIC -- requirements
Module: apb_rr_fabric

Interface
REQ-001 SHALL have parameter MST, default 2, the number of master ports (>=2).
REQ-002 SHALL have parameter SLV, default 4, the number of slave ports (>=1).
REQ-003 SHALL have parameter MST_ADDR, default 32, the master address width.
REQ-004 SHALL have parameter SLV_ADDR, default 12, the slave address width (< MST_ADDR).
REQ-005 SHALL have parameter DATA, default 32, the data width.
REQ-006 SHALL have parameter TIMEOUT, default 256, the ACCESS-cycle limit before timeout.
REQ-007 SHALL have port pclk, input, 1, the clock; reset preset_n, asynchronous, active-low; clock pclk.
REQ-008 SHALL have port preset_n, input, 1, the asynchronous active-low reset.
REQ-009 SHALL have master-side inputs mst_psel, mst_penable and mst_pwrite [MST], mst_pprot [MST][3], mst_paddr [MST][MST_ADDR], mst_pstrb [MST][4] and mst_pwdata [MST][DATA].
REQ-010 SHALL have master-side outputs mst_prdata [MST][DATA], mst_pslverr [MST] and mst_pready [MST].
REQ-011 SHALL have slave-side outputs slv_psel, slv_penable and slv_pwrite [SLV], slv_pprot [SLV][3], slv_paddr [SLV][SLV_ADDR], slv_pstrb [SLV][4] and slv_pwdata [SLV][DATA].
REQ-012 SHALL have slave-side inputs slv_prdata [SLV][DATA], slv_pslverr [SLV] and slv_pready [SLV].

Function
REQ-013 SHALL run a state machine with states IDLE, SETUP, ACCESS and ERR.
REQ-014 In IDLE with any mst_psel high, SHALL grant round-robin starting from the priority pointer, register the winner's pprot/paddr/pwrite/pstrb/pwdata, and go to SETUP.
REQ-015 SHALL compute the slave index as paddr[MST_ADDR-1:SLV_ADDR]; an index >= SLV SHALL be a decode error.
REQ-016 In SETUP, a decode error SHALL go to ERR with no slv_psel bit asserted.
REQ-017 In SETUP with a valid index, SHALL assert slv_psel[index] only with slv_penable low, then go to ACCESS.
REQ-018 In ACCESS, SHALL assert slv_psel[index] and slv_penable[index] until slv_pready[index] is high.
REQ-019 On the slv_pready cycle, SHALL drive the granted master's mst_pready=1, mst_prdata=slv_prdata[index] and mst_pslverr=slv_pslverr[index], then go to IDLE.
REQ-020 In ERR, SHALL drive the granted master's mst_pready=1, mst_pslverr=1 and mst_prdata=0 for one cycle, then go to IDLE.
REQ-021 On each completion, SHALL set the priority pointer to (winner+1) mod MST.
REQ-022 Zero-wait latency SHALL be: mst_psel sampled in IDLE at cycle T, SETUP at T+1, ACCESS with mst_pready at T+2.
REQ-023 SHALL drive mst_pready, mst_pslverr and mst_prdata of non-granted masters, and of all masters outside completion cycles, to 0.
REQ-024 SHALL broadcast the registered pprot, paddr[SLV_ADDR-1:0], pwrite, pstrb and pwdata to all slave ports; these values SHALL stay stable from SETUP through completion.
REQ-025 A granted master dropping mst_psel mid-transfer SHALL NOT abort the slave transfer; the response SHALL be discarded.
REQ-026 Requests from other masters during a transfer SHALL wait and SHALL be arbitrated only in IDLE.

Reset
REQ-027 On reset assertion, SHALL force IDLE, the pointer to 0, all slv_psel/slv_penable to 0, all mst_pready/mst_pslverr to 0, and the registered payload and timeout counter to 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer immediately without any response.

Configuration
REQ-029 With macro APB_RR_FABRIC_TIMEOUT_EN defined, a counter SHALL clear on entering ACCESS and increment each ACCESS cycle without slv_pready.
REQ-030 With APB_RR_FABRIC_TIMEOUT_EN defined, on the TIMEOUT-th cycle without slv_pready the block SHALL drop slv_psel/slv_penable, give the master mst_pready=1, mst_pslverr=1 and mst_prdata=0, and go to IDLE.
REQ-031 If slv_pready and timeout coincide, slv_pready SHALL win.
REQ-032 Without APB_RR_FABRIC_TIMEOUT_EN, ACCESS SHALL wait indefinitely and no counter logic SHALL exist.

Verification
REQ-033 Master0 reads 0x0000_1004 with a zero-wait slave returning 0xCAFE_F00D -> slv_psel[1] at T+1, slv_penable[1] at T+2, mst_prdata[0]=0xCAFE_F00D with mst_pready[0] at T+2.
REQ-034 Masters 0 and 1 request continuously after reset -> grants alternate 0,1,0,1 and each completes exactly once per pair.
REQ-035 Master1 writes 0x0000_5000 -> no slv_psel bit set, mst_pready[1]=1 and mst_pslverr[1]=1 at T+2.
REQ-036 Slave2 holds pready low for 3 cycles then returns pslverr=1 -> slv_paddr/pwdata stable throughout and mst_pslverr=1 on completion.
REQ-037 With TIMEOUT=8 and APB_RR_FABRIC_TIMEOUT_EN defined, slave never ready -> error response after 8 ACCESS cycles and slv_psel cleared.
REQ-038 preset_n asserted during ACCESS -> all outputs 0 immediately and next grant goes to master0.
